// File: rtl/data_wb_master.sv
// ----------------------------------------------------------------------------
// data_wb_master
//   Data-side Wishbone B3 classic master. Converts each single-cycle MEM-stage
//   request into exactly one Wishbone cycle, stalls the pipeline until the
//   slave acknowledges, and returns load data. The load word is held in rd_buf
//   while other pipeline stages keep the pipeline stalled.
//
// Optional feature macro: DWB_TIMEOUT_EN
//   When defined, a BUSY cycle counter aborts a cycle that has gone
//   TIMEOUT_CYCLES cycles without ack. The abort behaves like an ack with
//   data 0 and pulses bus_err_o for one cycle. When undefined there is no
//   counter, the TIMEOUT_CYCLES parameter does not exist, and bus_err_o is 0.
//
// Ports
//   clk, rst         core clock, synchronous active-high reset
//   stall_i[5:0]     pipeline stall vector from ctrl
//   flush_i          pipeline flush (exception / mret)
//   cpu_ce_i         MEM request valid
//   cpu_we_i         1 = store, 0 = load
//   cpu_addr_i       byte address
//   cpu_sel_i        byte lanes
//   cpu_data_i       store data, already lane-replicated
//   cpu_data_o       load data to the MEM stage (combinational)
//   stallreq_o       stall request to ctrl (combinational)
//   wb_*             registered Wishbone classic master signals
//   bus_err_o        one-cycle timeout pulse
// ----------------------------------------------------------------------------
module data_wb_master
`ifdef DWB_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    input  logic        cpu_ce_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BUSY       = 2'd1,
        WAIT_STALL = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] rd_buf;
    logic        start;
    logic        timeout_hit;

    assign start = (state == IDLE) && cpu_ce_i && !flush_i;

`ifdef DWB_TIMEOUT_EN
    // The counter holds the number of earlier BUSY cycles without ack, so
    // the abort fires in the TIMEOUT_CYCLES-th such cycle.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] to_cnt;
    assign timeout_hit = (state == BUSY) && !wb_ack_i && !flush_i && (to_cnt == TO_LAST);
`else
    assign timeout_hit = 1'b0;
    assign bus_err_o   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            rd_buf   <= '0;
`ifdef DWB_TIMEOUT_EN
            to_cnt    <= '0;
            bus_err_o <= 1'b0;
`endif
        end else begin
`ifdef DWB_TIMEOUT_EN
            bus_err_o <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        wb_adr_o <= cpu_addr_i;
                        wb_dat_o <= cpu_data_i;
                        wb_we_o  <= cpu_we_i;
                        wb_sel_o <= cpu_sel_i;
                        wb_stb_o <= 1'b1;
                        wb_cyc_o <= 1'b1;
                        state    <= BUSY;
`ifdef DWB_TIMEOUT_EN
                        to_cnt   <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (flush_i) begin
                        // Flush wins over a same-cycle ack: the access is dropped.
                        wb_adr_o <= '0;
                        wb_dat_o <= '0;
                        wb_we_o  <= 1'b0;
                        wb_sel_o <= '0;
                        wb_stb_o <= 1'b0;
                        wb_cyc_o <= 1'b0;
                        rd_buf   <= '0;
                        state    <= IDLE;
                    end else if (wb_ack_i || timeout_hit) begin
                        wb_adr_o <= '0;
                        wb_dat_o <= '0;
                        wb_we_o  <= 1'b0;
                        wb_sel_o <= '0;
                        wb_stb_o <= 1'b0;
                        wb_cyc_o <= 1'b0;
                        // A timed-out load returns zero in place of bus data.
                        if (!wb_we_o)
                            rd_buf <= wb_ack_i ? wb_dat_i : 32'h0000_0000;
`ifdef DWB_TIMEOUT_EN
                        bus_err_o <= timeout_hit;
`endif
                        state <= (stall_i != 6'd0) ? WAIT_STALL : IDLE;
                    end else begin
`ifdef DWB_TIMEOUT_EN
                        to_cnt <= to_cnt + 16'd1;
`endif
                    end
                end
                WAIT_STALL: begin
                    if (flush_i) begin
                        rd_buf <= '0;
                        state  <= IDLE;
                    end else if (stall_i == 6'd0) begin
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stallreq_o = start || ((state == BUSY) && !wb_ack_i && !flush_i);

    // Load data bypasses rd_buf in the ack cycle so the MEM stage sees it
    // without an extra cycle; afterwards rd_buf covers pipeline stalls.
    always_comb begin
        cpu_data_o = 32'h0000_0000;
        if ((state == BUSY) && wb_ack_i && !flush_i && !wb_we_o)
            cpu_data_o = wb_dat_i;
        else if (state == WAIT_STALL)
            cpu_data_o = rd_buf;
    end

endmodule

// File: tb/tb_data_wb_master.sv
module tb_data_wb_master;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        cpu_ce_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        wb_ack_i;
    logic        bus_err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifdef DWB_TIMEOUT_EN
    data_wb_master #(.TIMEOUT_CYCLES(4)) dut (
`else
    data_wb_master dut (
`endif
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
        .stallreq_o(stallreq_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
        .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i),
        .bus_err_o(bus_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; combinational
    // outputs are sampled one further unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic req(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat);
        cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = adr; cpu_sel_i = sel; cpu_data_i = dat;
    endtask

    task automatic req_clr();
        cpu_ce_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_sel_i = '0; cpu_data_i = '0;
    endtask

    initial begin
        rst = 1'b1; stall_i = '0; flush_i = 1'b0; wb_dat_i = '0; wb_ack_i = 1'b0;
        req_clr();
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_sel", wb_sel_o, 0);
        chk("rst_stallreq", stallreq_o, 0);
        chk("rst_data", cpu_data_o, 0);
        chk("rst_buserr", bus_err_o, 0);

        // 1: zero-wait load
        req(1'b0, 32'h3000_0004, 4'b1111, 32'h0);
        settle();
        chk("t1_stallreq_req", stallreq_o, 1);
        tick();
        req_clr();
        chk("t1_cyc", wb_cyc_o, 1);
        chk("t1_stb", wb_stb_o, 1);
        chk("t1_adr", wb_adr_o, 32'h3000_0004);
        chk("t1_we", wb_we_o, 0);
        wb_ack_i = 1'b1; wb_dat_i = 32'h1234_5678;
        settle();
        chk("t1_stallreq_ack", stallreq_o, 0);
        chk("t1_bypass", cpu_data_o, 32'h1234_5678);
        tick();
        wb_ack_i = 1'b0; wb_dat_i = '0;
        settle();
        chk("t1_cyc_drop", wb_cyc_o, 0);
        chk("t1_stb_drop", wb_stb_o, 0);
        chk("t1_adr_clr", wb_adr_o, 0);
        chk("t1_data_idle", cpu_data_o, 0);
        chk("t1_stallreq_idle", stallreq_o, 0);

        // 2: byte store with 3 wait states
        req(1'b1, 32'h1000_0002, 4'b0010, 32'hA5A5_A5A5);
        settle();
        chk("t2_stallreq_req", stallreq_o, 1);
        tick();
        req_clr();
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t2_cyc", wb_cyc_o, 1);
            chk("t2_we", wb_we_o, 1);
            chk("t2_sel", wb_sel_o, 4'b0010);
            chk("t2_adr", wb_adr_o, 32'h1000_0002);
            chk("t2_dat", wb_dat_o, 32'hA5A5_A5A5);
            if (i < 3) begin
                chk("t2_stallreq_wait", stallreq_o, 1);
                tick();
            end
        end
        wb_ack_i = 1'b1; wb_dat_i = 32'h5555_5555;
        settle();
        chk("t2_stallreq_ack", stallreq_o, 0);
        chk("t2_store_data", cpu_data_o, 0);
        tick();
        wb_ack_i = 1'b0; wb_dat_i = '0;
        settle();
        chk("t2_cyc_drop", wb_cyc_o, 0);
        chk("t2_we_drop", wb_we_o, 0);

        // 3: load acked under a 3-cycle external stall
        req(1'b0, 32'h2000_0000, 4'b1111, 32'h0);
        tick();
        req_clr();
        wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_BABE; stall_i = 6'b000011;
        settle();
        chk("t3_bypass", cpu_data_o, 32'hCAFE_BABE);
        tick();
        wb_ack_i = 1'b0; wb_dat_i = '0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) stall_i = '0;
            settle();
            chk("t3_hold", cpu_data_o, 32'hCAFE_BABE);
            chk("t3_stallreq", stallreq_o, 0);
            chk("t3_cyc", wb_cyc_o, 0);
            tick();
        end
        settle();
        chk("t3_idle_data", cpu_data_o, 0);
        cpu_ce_i = 1'b1;
        settle();
        chk("t3_idle_accepts", stallreq_o, 1);
        cpu_ce_i = 1'b0;
        settle();

        // 4: flush in the 2nd BUSY cycle, then a late ack
        req(1'b0, 32'h3000_0010, 4'b1111, 32'h0);
        tick();
        req_clr();
        tick();
        settle();
        chk("t4_busy2_cyc", wb_cyc_o, 1);
        flush_i = 1'b1;
        settle();
        chk("t4_flush_stallreq", stallreq_o, 0);
        chk("t4_flush_data", cpu_data_o, 0);
        tick();
        flush_i = 1'b0;
        settle();
        chk("t4_cyc_drop", wb_cyc_o, 0);
        chk("t4_stb_drop", wb_stb_o, 0);
        chk("t4_rdbuf_clr", dut.rd_buf, 0);
        wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
        settle();
        chk("t4_late_ack_data", cpu_data_o, 0);
        chk("t4_late_ack_stallreq", stallreq_o, 0);
        tick();
        wb_ack_i = 1'b0; wb_dat_i = '0;
        settle();
        chk("t4_late_ack_cyc", wb_cyc_o, 0);

        // 5: reset in BUSY with a non-zero rd_buf
        req(1'b0, 32'h3000_0020, 4'b1111, 32'h0);
        tick();
        req_clr();
        wb_ack_i = 1'b1; wb_dat_i = 32'h1122_3344; stall_i = 6'b000001;
        tick();
        wb_ack_i = 1'b0; wb_dat_i = '0; stall_i = '0;
        settle();
        chk("t5_wait_data", cpu_data_o, 32'h1122_3344);
        tick();
        req(1'b1, 32'h4000_0000, 4'b1100, 32'h7777_0000);
        tick();
        req_clr();
        settle();
        chk("t5_busy_cyc", wb_cyc_o, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("t5_rst_cyc", wb_cyc_o, 0);
        chk("t5_rst_stb", wb_stb_o, 0);
        chk("t5_rst_we", wb_we_o, 0);
        chk("t5_rst_adr", wb_adr_o, 0);
        chk("t5_rst_dat", wb_dat_o, 0);
        chk("t5_rst_sel", wb_sel_o, 0);
        chk("t5_rst_rdbuf", dut.rd_buf, 0);
        chk("t5_rst_stallreq", stallreq_o, 0);
        req(1'b0, 32'h3000_0008, 4'b0011, 32'h0);
        tick();
        req_clr();
        chk("t5_new_cyc", wb_cyc_o, 1);
        chk("t5_new_sel", wb_sel_o, 4'b0011);
        wb_ack_i = 1'b1; wb_dat_i = 32'h0BAD_F00D;
        settle();
        chk("t5_new_bypass", cpu_data_o, 32'h0BAD_F00D);
        tick();
        wb_ack_i = 1'b0; wb_dat_i = '0;

        // 6: slave that does not ack
        req(1'b0, 32'h5000_0000, 4'b1111, 32'h0);
        tick();
        req_clr();
`ifdef DWB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t6_cyc_busy", wb_cyc_o, 1);
            chk("t6_err_busy", bus_err_o, 0);
            tick();
        end
        settle();
        chk("t6_cyc_abort", wb_cyc_o, 0);
        chk("t6_err_pulse", bus_err_o, 1);
        chk("t6_data", cpu_data_o, 0);
        tick();
        settle();
        chk("t6_err_clear", bus_err_o, 0);
`else
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("t6_cyc_wait", wb_cyc_o, 1);
            chk("t6_stallreq_wait", stallreq_o, 1);
            chk("t6_no_err", bus_err_o, 0);
            tick();
        end
        wb_ack_i = 1'b1; wb_dat_i = 32'h0000_00AA;
        settle();
        chk("t6_final_ack", cpu_data_o, 32'h0000_00AA);
        tick();
        wb_ack_i = 1'b0; wb_dat_i = '0;
        settle();
        chk("t6_cyc_drop", wb_cyc_o, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
